// File: rtl/pll_reset_ctrl.sv
// Reset sequencer and lock supervisor for the system PLL, clocked by the 24 MHz refclk.
// Pulses the PLL reset, waits for a stable lock, then releases sys_reset; re-sequences on loss/timeout.
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 24,
  parameter int unsigned LOCK_TIMEOUT  = 24000,
  parameter int unsigned STABLE_CYCLES = 240
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic       lock_fail,
  output logic [7:0] loss_count,
  output logic [7:0] retry_count
);
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STB_LAST = 16'(STABLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        sync1, ext_sync;
  logic        retry_evt, loss_evt;

  // extlock comes straight from the PLL with no relation to refclk
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      ext_sync <= 1'b0;
    end else begin
      sync1    <= extlock;
      ext_sync <= sync1;
    end
  end

  // Lock beats timeout in WAIT_LOCK; a drop beats completion in STABLE.
  always_comb begin
    state_nxt = state;
    retry_evt = 1'b0;
    loss_evt  = 1'b0;
    case (state)
      RESET_PLL: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (ext_sync) state_nxt = STABLE;
        else if (cnt == TMO_LAST) begin
          state_nxt = RESET_PLL;
          retry_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!ext_sync) state_nxt = WAIT_LOCK;
        else if (cnt == STB_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!ext_sync) begin
          state_nxt = RESET_PLL;
          loss_evt  = 1'b1;
        end
      end
      default: state_nxt = RESET_PLL;
    endcase
  end

  // Reset outputs are loaded from the next-state decode so they are glitch-free flops.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      locked      <= 1'b0;
      lock_fail   <= 1'b0;
      loss_count  <= '0;
      retry_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      pll_reset <= (state_nxt == RESET_PLL);
      sys_reset <= (state_nxt != RUN);
      locked    <= (state_nxt == RUN);
      if (retry_evt) begin
        lock_fail <= 1'b1;
        if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      end
      if (loss_evt && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: deadline-based reference model feeds a per-edge
// expectation queue that a negedge monitor drains; directed sequences plus random extlock.
module tb_pll_reset_ctrl;
  localparam int RC = 4, LT = 20, SC = 8;
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STB = 2, PH_RUN = 3;

  logic       refclk = 1'b0, reset = 1'b0, extlock = 1'b0;
  logic       pll_reset, sys_reset, locked, lock_fail;
  logic [7:0] loss_count, retry_count;

  pll_reset_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC)) dut (
    .refclk(refclk), .reset(reset), .extlock(extlock),
    .pll_reset(pll_reset), .sys_reset(sys_reset), .locked(locked),
    .lock_fail(lock_fail), .loss_count(loss_count), .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic pr, sr, lk, lf;
    logic [7:0] lc, rc;
  } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;

  // Reference model: each phase has an absolute deadline edge; the synchronizer is
  // modelled as "the value used at edge e is the extlock sampled at edge e-2".
  int m_edge, m_ph, m_dl, m_loss, m_retry;
  bit m_fail;
  bit m_hist[2];

  function automatic void enter(int ph, int n);
    m_ph = ph;
    m_dl = m_edge + n;
  endfunction

  always @(posedge refclk or posedge reset) begin : model
    bit s;
    exp_t x;
    if (reset) begin
      m_edge = 0; m_ph = PH_RST; m_dl = RC;
      m_loss = 0; m_retry = 0; m_fail = 0;
      m_hist[0] = 0; m_hist[1] = 0;
      q.delete();
    end else begin
      m_edge++;
      s = m_hist[0];
      m_hist[0] = m_hist[1];
      m_hist[1] = extlock;
      case (m_ph)
        PH_RST:  if (m_edge == m_dl) enter(PH_WAIT, LT);
        PH_WAIT: begin
          if (s) enter(PH_STB, SC);
          else if (m_edge == m_dl) begin
            enter(PH_RST, RC);
            m_fail = 1;
            if (m_retry < 255) m_retry++;
          end
        end
        PH_STB: begin
          if (!s) enter(PH_WAIT, LT);
          else if (m_edge == m_dl) enter(PH_RUN, 0);
        end
        default: begin
          if (!s) begin
            enter(PH_RST, RC);
            if (m_loss < 255) m_loss++;
          end
        end
      endcase
      x.pr = (m_ph == PH_RST);
      x.sr = (m_ph != PH_RUN);
      x.lk = (m_ph == PH_RUN);
      x.lf = m_fail;
      x.lc = 8'(m_loss);
      x.rc = 8'(m_retry);
      q.push_back(x);
    end
  end

  always @(negedge refclk) begin : monitor
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      if ({pll_reset, sys_reset, locked, lock_fail, loss_count, retry_count} !==
          {x.pr, x.sr, x.lk, x.lf, x.lc, x.rc}) begin
        fails++;
        $display("FAIL edge_check edge %0d: got pr=%b sr=%b lk=%b lf=%b loss=%0d retry=%0d, want pr=%b sr=%b lk=%b lf=%b loss=%0d retry=%0d",
                 m_edge, pll_reset, sys_reset, locked, lock_fail, loss_count, retry_count,
                 x.pr, x.sr, x.lk, x.lf, x.lc, x.rc);
      end
    end
  end

  task automatic next();
    @(posedge refclk);
    #3;
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Asserts reset between edges, checks the asynchronous values, releases after one edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_pll_reset"}, pll_reset, 1);
    chk({tag, "_sys_reset"}, sys_reset, 1);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lock_fail"}, lock_fail, 0);
    chk({tag, "_loss_count"}, loss_count, 0);
    chk({tag, "_retry_count"}, retry_count, 0);
    next();
    reset = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_ph == ph) begin
        hit = 1;
        break;
      end
      next();
    end
    if (!hit) begin
      fails++;
      tests++;
      $display("FAIL %s: phase %0d not reached in %0d cycles (at %0d)", name, ph, budget, m_ph);
    end
  endtask

  initial begin
    #1;
    // 1. clean bring-up
    do_reset("init");
    repeat (10) next();
    extlock = 1'b1;                  // first sampled at edge 11
    repeat (10) next();
    chk("bringup_locked_early", locked, 0);
    next();
    chk("bringup_locked", locked, 1);
    chk("bringup_sys_reset", sys_reset, 0);
    chk("bringup_loss", loss_count, 0);
    chk("bringup_retry", retry_count, 0);

    // 4. lock loss in RUN: low at edges 27..29
    repeat (5) next();
    extlock = 1'b0;
    next();
    next();
    chk("loss_still_locked", locked, 1);
    next();
    chk("loss_pll_reset", pll_reset, 1);
    chk("loss_sys_reset", sys_reset, 1);
    chk("loss_locked", locked, 0);
    extlock = 1'b1;
    wait_phase(PH_RUN, 60, "loss_reacquire");
    chk("loss_count_one", loss_count, 1);

    // 5a. asynchronous reset while in RUN
    do_reset("run_reset");

    // 3. unstable lock: 5 synced-high cycles in STABLE, then a 2-cycle drop
    wait_phase(PH_STB, 20, "unstable_enter");
    repeat (3) next();
    extlock = 1'b0;
    repeat (2) next();
    extlock = 1'b1;
    wait_phase(PH_RUN, 60, "unstable_run");
    chk("unstable_retry", retry_count, 0);
    chk("unstable_lock_fail", lock_fail, 0);

    // 2. lock timeout until retry_count saturates
    extlock = 1'b0;
    repeat (258 * (RC + LT)) next();
    chk("timeout_retry_sat", retry_count, 255);
    chk("timeout_lock_fail", lock_fail, 1);
    chk("timeout_loss", loss_count, 1);

    // 5b. asynchronous reset while in STABLE clears saturated counts
    extlock = 1'b1;
    wait_phase(PH_STB, 60, "stable_enter");
    next();
    do_reset("stable_reset");

    // 6. lock arrives on the last timeout cycle (ext_sync high at edge 24)
    extlock = 1'b0;
    do_reset("simul_reset");
    repeat (21) next();
    extlock = 1'b1;
    repeat (3) next();
    chk("simul_retry", retry_count, 0);
    chk("simul_lock_fail", lock_fail, 0);
    chk("simul_pll_reset", pll_reset, 0);
    wait_phase(PH_RUN, 30, "simul_run");

    // randomized extlock segments with occasional async resets
    for (int seg = 0; seg < 80; seg++) begin
      extlock = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) next();
      if ($urandom_range(0, 24) == 0) do_reset("rand_reset");
    end

    repeat (3) next();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
